// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// Request fields are sampled by the unit only while it is idle.
// master = environment (CPU + memory), slave = load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 12
);
  // CPU side
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           rdata;
  // memory side
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [31:0]           mem_data;
  logic                  mem_we;
  logic [31:0]           mem_q;

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_q,
    input  busy, done, err, rdata,
    input  mem_read_addr, mem_write_addr, mem_data, mem_we
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_q,
    output busy, done, err, rdata,
    output mem_read_addr, mem_write_addr, mem_data, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide memory with 1-cycle read latency.
// Latency accept->done: misaligned 1, word store 2, load 3, sub-word store 4 cycles.
// No backpressure: one access at a time; req is ignored while busy.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  mis_q, mis_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;

  logic [31:0]           shifted;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [31:0]           load_val;
  logic [31:0]           merge;
  logic                  mis_in;

  // Address bits above the memory's word range wrap around.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = |lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Lane extraction for loads and read-modify-write merge for sub-word stores.
  always_comb begin
    shifted  = bus.mem_q >> {addr_q[1:0], 3'b000};
    byte_v   = shifted[7:0];
    half_v   = addr_q[1] ? bus.mem_q[31:16] : bus.mem_q[15:0];
    load_val = bus.mem_q;
    merge    = bus.mem_q;
    case (size_q)
      2'b00: begin
        load_val = {{24{sext_q & byte_v[7]}}, byte_v};
        merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{sext_q & half_v[15]}}, half_v};
        merge[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: begin
        load_val = bus.mem_q;
        merge    = bus.mem_q;
      end
    endcase
  end

  assign mis_in = misaligned(bus.size, bus.addr[1:0]);

  // Next-state and next-value logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    rdata_d    = rdata_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          sext_d  = bus.sign_ext;
          addr_d  = bus.addr[ADDR_WIDTH+1:0];
          wdata_d = bus.wdata[15:0];
          mis_d   = mis_in;
          if (mis_in) begin
            state_d = DONE;
          end else if (bus.we && bus.size == 2'b10) begin
            state_d    = WR;
            mem_data_d = bus.wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (we_q) begin
          mem_data_d = merge;
          state_d    = WR;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state_d == DONE) && mis_d;
    wr_d   = (state_d == WR);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      rdata_q    <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mis_q      <= mis_d;
      rdata_q    <= rdata_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.rdata          = rdata_q;
  assign bus.mem_read_addr  = addr_q[ADDR_WIDTH+1:2];
  assign bus.mem_write_addr = addr_q[ADDR_WIDTH+1:2];
  assign bus.mem_data       = mem_data_q;
  // A reset arriving during WR must not let the write through at that edge.
  assign bus.mem_we         = wr_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(12)) bus();
  load_store_unit #(.ADDR_WIDTH(12)) dut (.clock(clk), .reset(rst), .bus(bus.slave));

  // Memory model: registered read, write on mem_we, plus a backdoor port.
  logic [31:0] mem [0:4095];
  logic [31:0] mem_q_r;
  logic        bd_en = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  assign bus.mem_q = mem_q_r;
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_write_addr] <= bus.mem_data;
    mem_q_r <= mem[bus.mem_read_addr];
  end

  int total = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic err; logic [31:0] rdata; int lat;} exp_t;
  typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
  exp_t done_exp[$];
  wr_t  wr_exp[$];
  exp_t e_tmp;
  wr_t  w_tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic exp_done(input logic err, input logic [31:0] rd, input int lat);
    exp_t e;
    e.err = err; e.rdata = rd; e.lat = lat;
    done_exp.push_back(e);
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_exp.push_back(w);
  endtask

  // Monitor: pops expectations whenever the DUT completes or writes.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.done) chk("err_without_done", {31'b0, bus.err}, 32'd0);
      if (bus.done) begin
        if (done_exp.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e_tmp = done_exp.pop_front();
          chk("done_err", {31'b0, bus.err}, {31'b0, e_tmp.err});
          chk("done_rdata", bus.rdata, e_tmp.rdata);
          chk("done_latency", cyc - acc_cyc, e_tmp.lat);
        end
      end
      if (bus.mem_we) begin
        if (wr_exp.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          w_tmp = wr_exp.pop_front();
          chk("wr_addr", {20'b0, bus.mem_write_addr}, {20'b0, w_tmp.a});
          chk("wr_data", bus.mem_data, w_tmp.d);
        end
      end
      if (!bus.busy && bus.req) acc_cyc = cyc;
    end
  end

  task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d);
    bus.we = w; bus.size = s; bus.sign_ext = se; bus.addr = a; bus.wdata = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("timeout_idle", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #2 drive(w, s, se, a, d);
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle;
    int n;
    rst = 1'b1;
    bus.req = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'b0, bus.busy},   32'd0);
    chk("rst_done",   {31'b0, bus.done},   32'd0);
    chk("rst_err",    {31'b0, bus.err},    32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_rdata",  bus.rdata,           32'd0);
    chk("rst_mem_data", bus.mem_data,      32'd0);
    chk("rst_raddr",  {20'b0, bus.mem_read_addr},  32'd0);
    chk("rst_waddr",  {20'b0, bus.mem_write_addr}, 32'd0);
    rst = 1'b0;

    // word store
    exp_wr(12'd4, 32'hDEADBEEF); exp_done(1'b0, 32'h0, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("mem4_word_store", mem[4], 32'hDEADBEEF);

    // byte store read-modify-write
    bd_write(12'd4, 32'h11223344);
    exp_wr(12'd4, 32'h11AA3344); exp_done(1'b0, 32'h0, 4);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);

    // loads with sign/zero extension
    bd_write(12'd4, 32'h8000F0FF);
    exp_done(1'b0, 32'hFFFFFFFF, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    exp_done(1'b0, 32'h00008000, 3);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);

    // misaligned / illegal: err, 1 cycle, no write, rdata held
    exp_done(1'b1, 32'h00008000, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    exp_done(1'b1, 32'h00008000, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    exp_done(1'b1, 32'h00008000, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF);
    chk("mem4_after_misaligned", mem[4], 32'h8000F0FF);

    // half store to upper lane; upper wdata bits must be ignored
    exp_wr(12'd4, 32'h1234F0FF); exp_done(1'b0, 32'h00008000, 4);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);

    // more load lanes
    exp_done(1'b0, 32'h00001234, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    exp_done(1'b0, 32'hFFFFFFF0, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    exp_done(1'b0, 32'h00000012, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);

    // address wrap-around above bit 13
    exp_wr(12'd4, 32'hCAFEF00D); exp_done(1'b0, 32'h00000012, 2);
    issue(1'b1, 2'b10, 1'b0, 32'h00004010, 32'hCAFEF00D);
    exp_done(1'b0, 32'hCAFEF00D, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // reset during WR of a byte store aborts it
    bd_write(12'd8, 32'h55667788);
    @(posedge clk);
    #2 drive(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000011);
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_in_wr_busy", {31'b0, bus.busy},   32'd1);
    chk("abort_mem_we",     {31'b0, bus.mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_after", {31'b0, bus.busy}, 32'd0);
    chk("abort_done_after", {31'b0, bus.done}, 32'd0);
    chk("abort_rdata_reset", bus.rdata, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_mem8_unchanged", mem[8], 32'h55667788);

    // req held high: second access accepted only after DONE
    exp_done(1'b0, 32'hCAFEF00D, 3);
    exp_done(1'b0, 32'h000000CA, 3);
    @(posedge clk);
    #2 drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    bus.req = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("timeout_b2b_done", 32'd1, 32'd0);
    idle = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.busy) idle++;
      else break;
    end
    bus.req = 1'b0;
    chk("b2b_idle_cycles", idle, 32'd1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("pending_done", done_exp.size(), 32'd0);
    chk("pending_wr",   wr_exp.size(),   32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word-address width of the data memory port.
REQ-002 clock  input  1  sole clock; all state changes on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  1  CPU access request, sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 sign_ext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; 1 = misaligned or illegal access.
REQ-013 rdata  output  32  load result, held until the next load completes.
REQ-014 mem_read_addr, mem_write_addr  output  ADDR_WIDTH  word address = latched addr[ADDR_WIDTH+1:2].
REQ-015 mem_data  output  32  write data to memory.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_q  input  32  memory read data, registered in memory, valid one clock after mem_read_addr is sampled.

Function
REQ-018 The block SHALL use states IDLE, RD, CAP, WR and DONE.
REQ-019 In IDLE with req=1, the block SHALL latch we, size, sign_ext, addr and wdata; req SHALL be ignored in all other states.
REQ-020 Misaligned access SHALL mean size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
REQ-021 On accepting a misaligned request, IDLE SHALL go to DONE with err=1; no memory write SHALL occur and rdata SHALL be unchanged.
REQ-022 Transition paths SHALL be as follows:
- word store: IDLE->WR->DONE
- load: IDLE->RD->CAP->DONE
- byte/half store: IDLE->RD->CAP->WR->DONE
- DONE->IDLE always.
REQ-023 Latency from the accepting edge to the done cycle SHALL be: misaligned 1, word store 2, load 3, sub-word store 4 cycles.
REQ-024 mem_read_addr and mem_write_addr SHALL always equal the latched word address.
REQ-025 In CAP for a load, the block SHALL extract the lane from mem_q (little-endian):
- byte lane = addr[1:0]
- half lane = addr[1]
- extend per sign_ext
- register the result into rdata at the CAP->DONE edge.
REQ-026 In CAP for a sub-word store, the block SHALL register merge = mem_q with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0].
REQ-027 mem_data SHALL equal wdata for word stores and merge for sub-word stores.
REQ-028 mem_we SHALL be 1 only in WR and only when reset=0 (exactly one write per store).
REQ-029 done SHALL be 1 only in DONE; err SHALL be 0 whenever done=0.
REQ-030 A new req SHALL be accepted at the earliest in the cycle after DONE (back-to-back throughput bounded by REQ-023 plus 1).
REQ-031 Address bits above ADDR_WIDTH+1 SHALL be ignored (wrap-around).

Reset
REQ-032 Reset SHALL force IDLE with outputs busy=0, done=0, err=0, mem_we=0, rdata=0, mem_data=0, and latched address=0.
REQ-033 Reset asserted in any state SHALL abort the operation:
- no done pulse
- no memory write at that edge (reset in WR suppresses mem_we).

Verification
REQ-034 Store req we=1 size=10 addr=0x10 wdata=0xDEADBEEF -> mem_we high one cycle with write_addr=4, data 0xDEADBEEF; done 2 cycles after accept, err=0.
REQ-035 Memory word 4=0x11223344; store size=00 addr=0x12 wdata=0xAA -> one write of 0x11AA3344 to word 4; done 4 cycles after accept.
REQ-036 Word 4=0x8000F0FF; load size=00 addr=0x10 sign_ext=1 -> rdata=0xFFFFFFFF; load size=01 addr=0x12 sign_ext=0 -> rdata=0x00008000; each done 3 cycles after accept.
REQ-037 Load size=10 addr=0x13 -> done with err=1 1 cycle after accept, no mem_we, rdata unchanged; size=11 -> same.
REQ-038 Sub-word store with reset asserted in the WR cycle -> mem_we=0, no done, memory word unchanged, busy=0 next cycle.
REQ-039 req held high continuously during a load -> second request accepted only in the cycle after done; busy low exactly one cycle between the two operations.
